ctrl_irq_decoder: RTL
=====================

# ctrl_irq_decoder

Registered instruction-decode control unit with a multi-line interrupt controller. It sits between the ID and EX pipeline registers of the pipelined MIPS core. It decodes OpCode/Funct into the full control bundle, substitutes interrupt and exception bundles, and presents the result one cycle later as the ID/EX control register. It adds prioritised, sticky, kernel-masked interrupts with acknowledge, plus pipeline stall and flush.

## Interface
- IRQ_N, 4: number of level-sensitive interrupt lines, 1..16; line 0 has the highest priority.
- IRQ_IDW, $clog2(IRQ_N) (minimum 1): width of the interrupt index.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq  in  IRQ_N  level interrupt requests.
- in_valid  in  1  ID stage holds a real instruction.
- opcode, funct  in  6 each  instruction fields.
- pc_kernel  in  1  PC[31] of the ID instruction; 1 means supervisor mode.
- stall  in  1  hold the ID/EX register.
- flush  in  1  load a bubble into the ID/EX register.
- ex_valid  out  1  the bundle is live.
- ex_pcsrc  out  3  PC source.
- ex_regdst, ex_memtoreg  out  2 each  destination register and writeback source selects.
- ex_regwrite, ex_memread, ex_memwrite, ex_sign, ex_alusrc1, ex_alusrc2, ex_extop, ex_luop  out  1 each  control bits.
- ex_alufun  out  6  ALU function code.
- irq_ack  out  IRQ_N  one-hot, one-cycle pulse when a line is taken.
- irq_id  out  IRQ_IDW  index of the last taken line.
- irq_busy  out  1  FSM is in TAKEN or KERNEL.
- exc_cnt  out  16  undefined-opcode count (see Configuration).

## Operation
- **Legal opcodes:** 00–0C, 0F, 23, 2B. Any other opcode with in_valid=1 is an exception.
- **Exception bundle:** pcsrc=101, regdst=11 ($k0), memtoreg=10, regwrite=1.
- **IRQ bundle:** pcsrc=100, regdst=11, memtoreg=11 (current PC), regwrite=1, all other controls 0.
- **pcsrc (normal decode):**
  - 001: beq, bne, blez, bgtz, bltz.
  - 010: j, jal.
  - 011: jr (funct 08), jalr (funct 09).
  - 000: everything else.
- **regdst:** 10 for jal; 01 for opcode 00; 00 otherwise.
- **memtoreg:** 01 for lw; 10 for jal/jalr; 00 otherwise.
- **regwrite:** 0 for sw, branches, j, jr; 1 otherwise.
- **sign:** 0 for sltu and sltiu; 1 otherwise.
- **alusrc1:** 1 for sll, srl, sra.
- **alusrc2:** 0 for opcode 00 and beq; 1 otherwise.
- **extop:** 0 for andi only. **luop:** 1 for lui only.
- **memread:** 1 for lw (23). **memwrite:** 1 for sw (2B).
- **alufun:**
  - 000001: sub, subu.
  - 011000: and, andi.
  - 011110: or. 010110: xor. 010001: nor.
  - 100000: sll. 100001: srl. 100011: sra.
  - 110101: slt, sltu, slti, sltiu.
  - Branches: beq 110011, bne 110001, blez 111101, bgtz 111111, bltz 111011.
  - 000000: otherwise.
- **Pending register:** `pend |= irq` every cycle. Bits clear only on their own ack.
- **FSM states IDLE, PEND, TAKEN, KERNEL:**
  - IDLE→PEND when pend is nonzero.
  - PEND→TAKEN when in_valid=1, pc_kernel=0, stall=0 and flush=0. The registered bundle becomes the IRQ bundle, replacing the ID instruction.
  - In that same edge, select the lowest-index pending line: pulse its irq_ack bit, latch irq_id, and clear its pend bit.
  - TAKEN→KERNEL unconditionally after one cycle.
  - KERNEL→IDLE when jr decodes with in_valid=1, pc_kernel=1 and stall=0, or PEND if pend is still nonzero.
- **Priority:** IRQ over exception over normal decode. Interrupts are masked while pc_kernel=1 or the FSM is in TAKEN/KERNEL; exceptions are never masked.

## Timing
- One-cycle latency from ID inputs to ex_* outputs; all outputs are registered.
- **Reset:** every ex_* output, irq_ack, irq_id, irq_busy, pend and exc_cnt go to 0, and the FSM goes to IDLE, asynchronously.
- **stall=1:** ex_* hold; the FSM does not leave PEND; pend still accumulates.
- **flush=1:** the next ex_* is a bubble (all zero, ex_valid=0). flush beats stall.
- **in_valid=0:** bubble.
- **Lines rising simultaneously:** lowest index is acked first; the others stay pending and are taken after the KERNEL exit.
- **irq dropping while in PEND:** the request stays pending because pend is sticky.
- **Reset mid-handler:** pending requests are lost by design.

## Configuration
- **CTRL_EXC_CNT_EN defined:** exc_cnt increments once per registered exception bundle, saturating at FFFF.
- **Not defined:** exc_cnt is constant 0 and no counter logic exists.

## Test plan
- Reset low with irq=4'hF → all outputs 0; after release, no ack until in_valid=1 with pc_kernel=0.
- add (op 00, funct 20) with in_valid=1 → next cycle ex_regdst=01, ex_alufun=000000, ex_regwrite=1, ex_valid=1; then bne → ex_pcsrc=001, ex_alufun=110001, ex_regwrite=0.
- irq=4'b0110 rising together, user code → ack 0010 and irq_id=1, bundle pcsrc=100; after jr with pc_kernel=1 → ack 0100 and irq_id=2.
- irq[0] pulsed for one cycle while stall=1 for 3 cycles → no ack during stall; ack 0001 on the first unstalled cycle.
- Opcode 3F → pcsrc=101, regdst=11, memtoreg=10; with CTRL_EXC_CNT_EN, three such instructions → exc_cnt=3.
- IRQ pending coinciding with flush=1 → bubble, no ack; ack on the next unflushed valid user instruction.

Source files
------------

// File: rtl/ctrl_irq_decoder.sv
// ID/EX control register: instruction decode plus prioritised, sticky, kernel-masked interrupts.
// Optional feature: define CTRL_EXC_CNT_EN to get a saturating undefined-opcode counter on exc_cnt.
module ctrl_irq_decoder #(
    parameter int IRQ_N   = 4,
    parameter int IRQ_IDW = (IRQ_N > 1) ? $clog2(IRQ_N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IRQ_N-1:0]   irq,
    input  logic               in_valid,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               pc_kernel,
    input  logic               stall,
    input  logic               flush,
    output logic               ex_valid,
    output logic [2:0]         ex_pcsrc,
    output logic [1:0]         ex_regdst,
    output logic [1:0]         ex_memtoreg,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ex_sign,
    output logic               ex_alusrc1,
    output logic               ex_alusrc2,
    output logic               ex_extop,
    output logic               ex_luop,
    output logic [5:0]         ex_alufun,
    output logic [IRQ_N-1:0]   irq_ack,
    output logic [IRQ_IDW-1:0] irq_id,
    output logic               irq_busy,
    output logic [15:0]        exc_cnt
);

    typedef struct packed {
        logic       valid;
        logic [2:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       sign;
        logic       alusrc1;
        logic       alusrc2;
        logic       extop;
        logic       luop;
        logic [5:0] alufun;
    } bundle_t;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_TAKEN, S_KERNEL} state_t;

    localparam bundle_t C_IRQ_BUNDLE = {1'b1, 3'b100, 2'b11, 2'b11, 1'b1, 7'b0000000, 6'b000000};
    localparam bundle_t C_EXC_BUNDLE = {1'b1, 3'b101, 2'b11, 2'b10, 1'b1, 7'b0000000, 6'b000000};

    bundle_t            r_bundle, w_bundle_nx, w_dec;
    state_t             r_state, w_state_nx;
    logic [IRQ_N-1:0]   r_pend, r_ack, w_sel_oh;
    logic [IRQ_IDW-1:0] r_id, w_sel_idx;
    logic               r_busy, w_legal, w_take, w_jr;

    assign w_jr = (opcode == 6'h00) && (funct == 6'h08);

    // Normal instruction decode; unknown opcodes flag an exception.
    always_comb begin
        w_dec          = '0;
        w_dec.valid    = 1'b1;
        w_dec.regwrite = 1'b1;
        w_dec.sign     = 1'b1;
        w_dec.alusrc2  = 1'b1;
        w_dec.extop    = 1'b1;
        w_legal        = 1'b1;
        case (opcode)
            6'h00: begin
                w_dec.regdst  = 2'b01;
                w_dec.alusrc2 = 1'b0;
                case (funct)
                    6'h00: begin w_dec.alusrc1 = 1'b1; w_dec.alufun = 6'b100000; end
                    6'h02: begin w_dec.alusrc1 = 1'b1; w_dec.alufun = 6'b100001; end
                    6'h03: begin w_dec.alusrc1 = 1'b1; w_dec.alufun = 6'b100011; end
                    6'h08: begin w_dec.pcsrc = 3'b011; w_dec.regwrite = 1'b0; end
                    6'h09: begin w_dec.pcsrc = 3'b011; w_dec.memtoreg = 2'b10; end
                    6'h22, 6'h23: w_dec.alufun = 6'b000001;
                    6'h24: w_dec.alufun = 6'b011000;
                    6'h25: w_dec.alufun = 6'b011110;
                    6'h26: w_dec.alufun = 6'b010110;
                    6'h27: w_dec.alufun = 6'b010001;
                    6'h2A: w_dec.alufun = 6'b110101;
                    6'h2B: begin w_dec.alufun = 6'b110101; w_dec.sign = 1'b0; end
                    default: w_dec.alufun = 6'b000000;
                endcase
            end
            6'h01: begin w_dec.pcsrc = 3'b001; w_dec.regwrite = 1'b0; w_dec.alufun = 6'b111011; end
            6'h02: begin w_dec.pcsrc = 3'b010; w_dec.regwrite = 1'b0; end
            6'h03: begin w_dec.pcsrc = 3'b010; w_dec.regdst = 2'b10; w_dec.memtoreg = 2'b10; end
            6'h04: begin
                w_dec.pcsrc    = 3'b001;
                w_dec.regwrite = 1'b0;
                w_dec.alusrc2  = 1'b0;
                w_dec.alufun   = 6'b110011;
            end
            6'h05: begin w_dec.pcsrc = 3'b001; w_dec.regwrite = 1'b0; w_dec.alufun = 6'b110001; end
            6'h06: begin w_dec.pcsrc = 3'b001; w_dec.regwrite = 1'b0; w_dec.alufun = 6'b111101; end
            6'h07: begin w_dec.pcsrc = 3'b001; w_dec.regwrite = 1'b0; w_dec.alufun = 6'b111111; end
            6'h08, 6'h09: w_dec.alufun = 6'b000000;
            6'h0A: w_dec.alufun = 6'b110101;
            6'h0B: begin w_dec.alufun = 6'b110101; w_dec.sign = 1'b0; end
            6'h0C: begin w_dec.alufun = 6'b011000; w_dec.extop = 1'b0; end
            6'h0F: w_dec.luop = 1'b1;
            6'h23: begin w_dec.memread = 1'b1; w_dec.memtoreg = 2'b01; end
            6'h2B: begin w_dec.memwrite = 1'b1; w_dec.regwrite = 1'b0; end
            default: w_legal = 1'b0;
        endcase
    end

    // Lowest-index pending line wins.
    always_comb begin
        w_sel_idx = '0;
        w_sel_oh  = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel_idx   = IRQ_IDW'(i);
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
            end else begin
                w_sel_idx = w_sel_idx;
            end
        end
    end

    // Interrupt FSM next state; the take replaces a user-mode ID instruction.
    always_comb begin
        w_state_nx = r_state;
        w_take     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pend) w_state_nx = S_PEND;
                else         w_state_nx = S_IDLE;
            end
            S_PEND: begin
                if (in_valid && !pc_kernel && !stall && !flush && (|r_pend)) begin
                    w_take     = 1'b1;
                    w_state_nx = S_TAKEN;
                end else begin
                    w_state_nx = S_PEND;
                end
            end
            S_TAKEN: w_state_nx = S_KERNEL;
            S_KERNEL: begin
                if (w_jr && in_valid && pc_kernel && !stall) w_state_nx = (|r_pend) ? S_PEND : S_IDLE;
                else                                         w_state_nx = S_KERNEL;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Next ID/EX bundle: flush, then stall, then IRQ, bubble, exception, decode.
    always_comb begin
        w_bundle_nx = r_bundle;
        if (flush)          w_bundle_nx = '0;
        else if (stall)     w_bundle_nx = r_bundle;
        else if (w_take)    w_bundle_nx = C_IRQ_BUNDLE;
        else if (!in_valid) w_bundle_nx = '0;
        else if (!w_legal)  w_bundle_nx = C_EXC_BUNDLE;
        else                w_bundle_nx = w_dec;
    end

    // State, pending, acknowledge and bundle registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pend   <= '0;
            r_ack    <= '0;
            r_id     <= '0;
            r_busy   <= 1'b0;
            r_bundle <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_pend   <= (r_pend | irq) & ~(w_take ? w_sel_oh : {IRQ_N{1'b0}});
            r_ack    <= w_take ? w_sel_oh : {IRQ_N{1'b0}};
            r_id     <= w_take ? w_sel_idx : r_id;
            r_busy   <= (w_state_nx == S_TAKEN) || (w_state_nx == S_KERNEL);
            r_bundle <= w_bundle_nx;
        end
    end

`ifdef CTRL_EXC_CNT_EN
    logic [15:0] r_exc_cnt;
    logic        w_exc_load;
    assign w_exc_load = !flush && !stall && !w_take && in_valid && !w_legal;

    // Saturating count of registered exception bundles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    r_exc_cnt <= 16'd0;
        else if (w_exc_load && (r_exc_cnt != 16'hFFFF)) r_exc_cnt <= r_exc_cnt + 16'd1;
        else                                           r_exc_cnt <= r_exc_cnt;
    end
    assign exc_cnt = r_exc_cnt;
`else
    assign exc_cnt = 16'd0;
`endif

    assign ex_valid    = r_bundle.valid;
    assign ex_pcsrc    = r_bundle.pcsrc;
    assign ex_regdst   = r_bundle.regdst;
    assign ex_memtoreg = r_bundle.memtoreg;
    assign ex_regwrite = r_bundle.regwrite;
    assign ex_memread  = r_bundle.memread;
    assign ex_memwrite = r_bundle.memwrite;
    assign ex_sign     = r_bundle.sign;
    assign ex_alusrc1  = r_bundle.alusrc1;
    assign ex_alusrc2  = r_bundle.alusrc2;
    assign ex_extop    = r_bundle.extop;
    assign ex_luop     = r_bundle.luop;
    assign ex_alufun   = r_bundle.alufun;
    assign irq_ack     = r_ack;
    assign irq_id      = r_id;
    assign irq_busy    = r_busy;

endmodule
